crp16_alu_shifter_right_seq: RTL and testbench
==============================================

# crp16_alu_shifter_right_seq

Multi-cycle 16-bit right shifter for the CRP16 ALU, the right-direction counterpart to the combinational left barrel shifter. It takes an operand and a 4-bit shift amount through a start/done handshake and supports logical and arithmetic shifts. It also reports the last bit shifted out. It sits beside the left shifter in the ALU and lets the datapath trade latency for area on right shifts.

## Interface
Parameters:
- none (width fixed at 16, shift amount fixed at 4 bits)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is accepting (IDLE or DONE)
- x  input  16  operand; latched on accepted start
- shift  input  4  shift amount 0..15; latched on accepted start
- arith  input  1  1 = arithmetic (fill with x[15]), 0 = logical (fill with 0); latched on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; result valid
- out  output  16  result; updated only on entry to DONE, held otherwise
- carry  output  1  last bit shifted out; 0 when shift = 0; updated with out

## Operation
- Internal state: 16-bit accumulator acc, 4-bit remaining count cnt, latched fill bit, latched carry, and an FSM with states IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. On start=1: acc<=x, cnt<=shift, fill<=arith&x[15], carry_int<=0, next state SHIFT.
- SHIFT: busy=1. If cnt≠0: shift acc right by step k, insert k copies of fill at the MSB, set carry_int to the last bit shifted out (acc[k-1]), set cnt<=cnt-k, and stay in SHIFT. If cnt=0: out<=acc, carry<=carry_int, next state DONE.
- Step k is 1 in the base build (see Configuration).
- DONE: done=1, busy=0, lasts exactly one cycle. start=1 here is accepted exactly as in IDLE, going to SHIFT, so back-to-back operations are allowed. Otherwise the next state is IDLE.
- start during SHIFT is ignored, with no queuing.
- Result: out = x >> shift (logical) or $signed(x) >>> shift (arithmetic). carry = x[shift-1] for shift>0, else 0.
- Inputs x, shift and arith may change freely after acceptance.

## Timing
- Reset values: busy=0, done=0, out=16'h0000, carry=0. The FSM goes to IDLE, with acc=0 and cnt=0.
- Reset during SHIFT aborts the operation. No done pulse is produced, and out/carry return to 0.
- Reset wins over a simultaneous start.
- Let edge E be the edge that accepts start. Base latency: done is high in the cycle after edge E+shift+1. For example, shift=0 gives done in the cycle after edge E+1, and shift=15 gives it after edge E+16.
- out and carry become valid in the same cycle done rises, and hold until the next completion or reset.
- Minimum issue interval is shift+2 cycles, with start held high in the DONE cycle.

## Configuration
- Macro: CRP16_ALU_SHIFTER_RIGHT_FAST_EN.
- Defined: in SHIFT, k=4 when cnt≥4, else k=1. carry_int takes acc[3] on a 4-bit step. Latency from edge E to the done edge is floor(shift/4)+(shift mod 4)+1, so shift=15 gives 7 and shift=4 gives 2. Results are identical to the base build.
- Undefined: k=1 always; latency is shift+1.

## Test plan
- Logical shift: x=16'hF0F0, shift=4, arith=0 -> out=16'h0F0F, carry=0. done after 5 edges in base build, 2 edges in fast build.
- Arithmetic full shift: x=16'h8001, shift=15, arith=1 -> out=16'hFFFF, carry=0 (x[14]). done after 16 edges in base build, 7 in fast build. The same operands with arith=0 -> out=16'h0001, carry=0.
- Carry and zero shift: x=16'h0003, shift=1, logical -> out=16'h0001, carry=1. Then, back-to-back with start held in the DONE cycle, x=16'h1234, shift=0 -> out=16'h1234, carry=0, done one edge after acceptance.
- Busy protection: start x=16'h8000, shift=8, arith=1. Mid-SHIFT, pulse start with x=16'h0001, shift=1 -> ignored. Result is 16'hFF80, carry=0, with exactly one done pulse.
- Reset mid-op: start x=16'hFFFF, shift=12. Assert reset 3 cycles later -> busy=0, done never pulses, out=0, carry=0. A new start with x=16'h00F0, shift=4 -> 16'h000F, carry=0.
- Random compare: 1000 random (x, shift, arith) triples checked against the >> / >>> model in both builds. Check that done width is always exactly one cycle and that the latency formula holds.

Source files
------------

// File: rtl/crp16_alu_shifter_right_seq.sv
// CRP16 ALU multi-cycle 16-bit right shifter (logical/arithmetic) with start/done handshake.
// Optional 4-bit stepping when CRP16_ALU_SHIFTER_RIGHT_FAST_EN is defined.
module crp16_alu_shifter_right_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [3:0]  shift,
  input  logic        arith,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic        carry
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] acc, acc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        fill, fill_nxt;
  logic        carry_int, carry_int_nxt;
  logic [15:0] out_nxt;
  logic        carry_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      fill      <= 1'b0;
      carry_int <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      fill      <= fill_nxt;
      carry_int <= carry_int_nxt;
      out       <= out_nxt;
      carry     <= carry_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    fill_nxt      = fill;
    carry_int_nxt = carry_int;
    out_nxt       = out;
    carry_nxt     = carry;

    case (state)
      // DONE accepts a new start just like IDLE so operations can run back to back
      IDLE, DONE: begin
        if (start) begin
          acc_nxt       = x;
          cnt_nxt       = shift;
          fill_nxt      = arith & x[15];
          carry_int_nxt = 1'b0;
          state_nxt     = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end

      SHIFT: begin
        if (cnt != 4'd0) begin
`ifdef CRP16_ALU_SHIFTER_RIGHT_FAST_EN
          if (cnt >= 4'd4) begin
            acc_nxt       = {{4{fill}}, acc[15:4]};
            carry_int_nxt = acc[3];
            cnt_nxt       = cnt - 4'd4;
          end else begin
            acc_nxt       = {fill, acc[15:1]};
            carry_int_nxt = acc[0];
            cnt_nxt       = cnt - 4'd1;
          end
`else
          acc_nxt       = {fill, acc[15:1]};
          carry_int_nxt = acc[0];
          cnt_nxt       = cnt - 4'd1;
`endif
        end else begin
          out_nxt   = acc;
          carry_nxt = carry_int;
          state_nxt = DONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_crp16_alu_shifter_right_seq.sv
// Self-checking bench for crp16_alu_shifter_right_seq: cycle-level timing model plus >>/>>> reference.
module tb_crp16_alu_shifter_right_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] x;
  logic [3:0]  shift;
  logic        arith;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        carry;

  int checks = 0;
  int errors = 0;

  crp16_alu_shifter_right_seq dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .x     (x),
    .shift (shift),
    .arith (arith),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .carry (carry)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: edges from acceptance edge to the edge that raises done
  function automatic int unsigned lat_of(input int unsigned s);
`ifdef CRP16_ALU_SHIFTER_RIGHT_FAST_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  function automatic logic [16:0] ref_shift(input logic [15:0] a, input int unsigned s, input logic ar);
    logic [15:0] r;
    logic        c;
    if (ar) r = 16'($signed(a) >>> s);
    else    r = a >> s;
    c = (s == 0) ? 1'b0 : a[s-1];
    return {c, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model, evaluated at every negedge (inputs are stable then)
  bit          armed   = 1'b0;
  bit          pending = 1'b0;
  longint      n       = 0;
  longint      done_cyc;
  logic [15:0] m_out   = '0;
  logic        m_carry = 1'b0;
  logic [15:0] p_out;
  logic        p_carry;
  int          n_done  = 0;

  always @(negedge clock) begin
    logic        exp_done;
    logic [16:0] r;
    n++;
    exp_done = 1'b0;
    if (pending && n == done_cyc) begin
      m_out    = p_out;
      m_carry  = p_carry;
      pending  = 1'b0;
      exp_done = 1'b1;
      n_done++;
    end
    if (armed) begin
      chk("busy",  {31'd0, busy},  {31'd0, pending});
      chk("done",  {31'd0, done},  {31'd0, exp_done});
      chk("out",   {16'd0, out},   {16'd0, m_out});
      chk("carry", {31'd0, carry}, {31'd0, m_carry});
    end
    // Apply what the next rising edge will sample
    if (reset) begin
      armed   = 1'b1;
      pending = 1'b0;
      m_out   = '0;
      m_carry = 1'b0;
    end else if (armed && start && !pending) begin
      r        = ref_shift(x, int'(shift), arith);
      p_out    = r[15:0];
      p_carry  = r[16];
      pending  = 1'b1;
      done_cyc = n + 1 + longint'(lat_of(int'(shift)));
    end
  end

  // Issue one operation and return edges from acceptance to the done edge
  task automatic run_op(input logic [15:0] a, input logic [3:0] s, input logic ar,
                        output int edges, output bit ok);
    int k;
    start = 1'b1; x = a; shift = s; arith = ar;
    ok = 1'b0; edges = 0; k = 0;
    while (k < 40 && !ok) begin
      @(posedge clock); #1;
      k++;
      if (k == 1) start = 1'b0;
      if (done) ok = 1'b1;
    end
    edges = k - 1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout: no done within 40 edges for x=%h shift=%0d", a, s);
    end
  endtask

  task automatic wait_done(output bit ok);
    int k;
    ok = 1'b0; k = 0;
    while (k < 40 && !ok) begin
      @(posedge clock); #1;
      k++;
      if (done) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout: no done within 40 edges");
    end
  endtask

  int unsigned exp_lat4, exp_lat15;

  initial begin
    int edges;
    bit ok;
    int target;
    int cyc;

`ifdef CRP16_ALU_SHIFTER_RIGHT_FAST_EN
    exp_lat4 = 2; exp_lat15 = 7;
`else
    exp_lat4 = 5; exp_lat15 = 16;
`endif

    reset = 1'b1; start = 1'b0; x = '0; shift = '0; arith = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_done",  {31'd0, done},  32'd0);
    chk("reset_out",   {16'd0, out},   32'd0);
    chk("reset_carry", {31'd0, carry}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Logical shift
    run_op(16'hF0F0, 4'd4, 1'b0, edges, ok);
    chk("log4_out", {16'd0, out}, 32'h0F0F);
    chk("log4_carry", {31'd0, carry}, 32'd0);
    chk("log4_lat", edges, exp_lat4);
    @(posedge clock); #1;

    // Arithmetic full shift, then logical with same operands
    run_op(16'h8001, 4'd15, 1'b1, edges, ok);
    chk("ari15_out", {16'd0, out}, 32'hFFFF);
    chk("ari15_carry", {31'd0, carry}, 32'd0);
    chk("ari15_lat", edges, exp_lat15);
    @(posedge clock); #1;
    run_op(16'h8001, 4'd15, 1'b0, edges, ok);
    chk("log15_out", {16'd0, out}, 32'h0001);
    chk("log15_carry", {31'd0, carry}, 32'd0);
    @(posedge clock); #1;

    // Carry out, then back-to-back zero shift issued in the DONE cycle
    run_op(16'h0003, 4'd1, 1'b0, edges, ok);
    chk("c1_out", {16'd0, out}, 32'h0001);
    chk("c1_carry", {31'd0, carry}, 32'd1);
    run_op(16'h1234, 4'd0, 1'b0, edges, ok);
    chk("z0_out", {16'd0, out}, 32'h1234);
    chk("z0_carry", {31'd0, carry}, 32'd0);
    chk("z0_lat", edges, 32'd1);
    @(posedge clock); #1;

    // Start during SHIFT must be ignored
    start = 1'b1; x = 16'h8000; shift = 4'd8; arith = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    start = 1'b1; x = 16'h0001; shift = 4'd1; arith = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(ok);
    chk("busy_out", {16'd0, out}, 32'hFF80);
    chk("busy_carry", {31'd0, carry}, 32'd0);
    @(posedge clock); #1;

    // Reset mid-operation
    start = 1'b1; x = 16'hFFFF; shift = 4'd12; arith = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    repeat (15) @(posedge clock);
    #1;
    run_op(16'h00F0, 4'd4, 1'b0, edges, ok);
    chk("post_rst_out", {16'd0, out}, 32'h000F);
    chk("post_rst_carry", {31'd0, carry}, 32'd0);
    @(posedge clock); #1;

    // Random traffic: starts at any time (ignored when busy), rare resets
    target = n_done + 1000;
    cyc = 0;
    while (n_done < target && cyc < 60000) begin
      start = ($urandom_range(0, 2) == 0);
      x     = 16'($urandom);
      shift = 4'($urandom_range(0, 15));
      arith = 1'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      @(posedge clock); #1;
      cyc++;
    end
    reset = 1'b0; start = 1'b0;
    checks++;
    if (n_done < target) begin
      errors++;
      $display("FAIL random_budget: completed %0d required %0d", n_done, target);
    end
    repeat (20) @(posedge clock);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
